// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmitter arbiter.
//   state_t          : arbiter FSM states
//   DEF_NUM_REQ      : default requester count
//   ID_W             : requester index width for the default count
//   DEF_BUSY_TIMEOUT : default cycles to wait for tx_busy to rise
//   id_w()           : index width for an arbitrary requester count
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ      = 4;
  localparam int ID_W             = $clog2(DEF_NUM_REQ);
  localparam int DEF_BUSY_TIMEOUT = 4;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted request at or above
// i_ptr, wrapping from NUM_REQ-1 back to 0.
//   i_req   : request vector
//   i_ptr   : highest-priority index for this search
//   o_grant : one-hot winner (zero when no request)
//   o_idx   : binary winner index (zero when no request)
//   o_any   : at least one request asserted
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int GW      = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [GW-1:0]      o_idx,
  output logic               o_any
);

  logic [GW:0]   w_sum;
  logic [GW-1:0] w_pos;
  logic          w_found;

  assign o_any = |i_req;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr < NUM_REQ, so one conditional subtract is enough to wrap
      w_sum = {1'b0, i_ptr} + (GW+1)'(k);
      if (w_sum >= (GW+1)'(NUM_REQ)) w_sum = w_sum - (GW+1)'(NUM_REQ);
      w_pos = w_sum[GW-1:0];
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// producers. One byte is accepted per grant, handed to the transmitter
// with a single-cycle start pulse, and the next grant waits until the
// transmitter's busy flag has risen and fallen again (or never rose).
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_req_valid/_data     : per-requester byte offer, packed DATA_W slices
//   o_req_ready           : one-hot accept, only in IDLE with transmitter free
//   o_tx_start, o_tx_data : start pulse and held byte for the transmitter
//   i_tx_busy             : transmitter busy flag
//   o_grant_id            : owner of current / most recent frame
//   o_active              : frame in flight (accept until busy falls)
//   o_err_timeout         : one-cycle pulse when busy never rose
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ      = DEF_NUM_REQ,
  parameter  int DATA_W       = 8,
  parameter  int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  localparam int GW           = id_w(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_tx_start,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_busy,
  output logic [GW-1:0]             o_grant_id,
  output logic                      o_active,
  output logic                      o_err_timeout
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  state_t              r_state, w_state_nxt;
  logic [GW-1:0]       r_ptr, r_gid;
  logic [DATA_W-1:0]   r_data;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic                r_active, r_err;

  logic [NUM_REQ-1:0]  w_grant;
  logic [GW-1:0]       w_idx;
  logic                w_any;
  logic                w_accept, w_timeout, w_release;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    w_release   = 1'b0;
    o_req_ready = '0;
    o_tx_start  = 1'b0;
    case (r_state)
      IDLE: begin
        // the winner is always a valid requester, so ready implies accept
        if (!i_tx_busy && w_any) begin
          o_req_ready = w_grant;
          w_accept    = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        o_tx_start  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_state_nxt = WAIT_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_cnt_nxt == CW'(BUSY_TIMEOUT)) begin
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_gid    <= '0;
      r_data   <= '0;
      r_active <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_timeout;
      if (w_accept) begin
        r_data   <= i_req_data[w_idx*DATA_W +: DATA_W];
        r_gid    <= w_idx;
        r_ptr    <= (w_idx == GW'(NUM_REQ-1)) ? '0 : w_idx + GW'(1);
        r_active <= 1'b1;
      end else if (w_timeout || w_release) begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_tx_data     = r_data;
  assign o_grant_id    = r_gid;
  assign o_active      = r_active;
  assign o_err_timeout = r_err;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART_tx byte transmitter among NUM_REQ requesters.
- Accepts one byte per grant over a valid/ready handshake.
- Drives the transmitter's tx_start / data_in pair, then tracks tx_busy until the frame completes before granting again.
- Sits between the byte producers (command/status/log sources) and the single UART_tx instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the UART_tx data_in width.
- BUSY_TIMEOUT, 4, maximum cycles after tx_start to wait for tx_busy to rise before declaring a fault (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte-available flag.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs on the edge where req_valid[i] & req_ready[i] are both high.
- tx_start  out  1  one-cycle start pulse to UART_tx.
- tx_data  out  DATA_W  byte to UART_tx data_in; held stable from start until the frame ends.
- tx_busy  in  1  busy flag from UART_tx.
- grant_id  out  clog2(NUM_REQ)  index of the requester owning the current or most recent frame.
- active  out  1  high from the accept cycle until tx_busy falls (or timeout).
- err_timeout  out  1  one-cycle pulse when tx_busy fails to rise in time.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - Outputs: tx_start=0, tx_data=0, req_ready=0, grant_id=0, active=0, err_timeout=0.
  - Internal: state=IDLE, rr_ptr=0, timeout counter=0.
  - Reset mid-frame abandons the frame immediately; no requester is re-acknowledged. UART_tx is reset by the same rst.
- States are IDLE, START, WAIT_BUSY and WAIT_DONE.
- IDLE:
  - req_ready is combinational: one-hot of the round-robin winner, asserted only when state==IDLE, tx_busy==0 and any req_valid is high.
  - Winner is the first asserted req_valid searching from rr_ptr upward, wrapping at NUM_REQ-1 to 0.
  - On the accept edge: tx_data<=req_data[winner], grant_id<=winner, rr_ptr<=(winner+1) mod NUM_REQ, active<=1, go to START.
  - If tx_busy==1 in IDLE (foreign or lingering frame), nothing is granted.
- START:
  - tx_start=1 for exactly this one cycle, i.e. accept cycle T -> tx_start high in T+1.
  - Clear timeout counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy==1 -> WAIT_DONE.
  - Otherwise increment the counter; when it reaches BUSY_TIMEOUT, pulse err_timeout for one cycle, set active<=0 and go to IDLE. The byte is dropped and the requester is not retried.
- WAIT_DONE:
  - Stay while tx_busy==1.
  - On tx_busy==0, set active<=0 and go to IDLE; the next grant is possible in the following cycle.
- Requester rules:
  - req_data must be stable while req_valid is high and unacknowledged.
  - req_valid may not drop before ready; the bench checks this as an assertion on the stimulus.
- Simultaneous events:
  - Multiple valids resolve purely by rr_ptr.
  - A requester re-asserting immediately after its grant has lowest priority in the next arbitration.
- tx_data and grant_id keep their last values after the frame ends; only active indicates ownership.
- Throughput: at most one byte per frame. Between two frames there are at least 2 cycles of IDLE/START overhead plus the UART_tx busy time.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE, START, WAIT_BUSY, WAIT_DONE);
  - localparam ID_W = clog2(NUM_REQ);
  - a default BUSY_TIMEOUT constant.
- One sub-module, rr_pick: combinational round-robin search.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, binary index, any_valid.
  - rr_ptr register and FSM stay in the top.

Test Plan:
- Reset, then req_valid=4'b0001 with data 8'hA5, UART_tx model busy 100 cycles:
  - req_ready[0] for one cycle; tx_start one cycle later with tx_data=8'hA5; grant_id=0.
  - active falls the cycle after tx_busy falls.
- All four valid simultaneously with bytes 8'h11/22/33/44:
  - tx_data sequence is 11,22,33,44; grant_id 0,1,2,3.
  - No two tx_start pulses while tx_busy is high.
- req0 held continuously valid, req2 valid with 8'h3C:
  - Grants alternate 0,2,0,2; req2 never waits more than one frame.
- tx_busy tied low (UART absent), req1 valid:
  - tx_start pulse, then err_timeout pulse exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY.
  - active=0 afterwards and the next request is granted normally.
- Force tx_busy=1 in IDLE with req3 valid:
  - req_ready stays 0; the grant occurs the cycle after tx_busy drops.
- Assert rst during WAIT_DONE:
  - Next cycle all outputs at reset values and rr_ptr=0.
  - A pending req2 after reset is granted only when tx_busy==0.
